contador_palabras: RTL and testbench

Word-counter stage sitting directly downstream of the four output FIFOs of the transaction layer. It counts every word actually popped from each output FIFO and answers probe read requests (`req`/`idx`) with the selected count on `contador`, qualified by `valid`. Reads are served only while the main control FSM reports IDLE. A request that arrives outside IDLE is held until IDLE is reached.

---
 rtl/contador_palabras_if.sv | 21 ++
 rtl/contador_palabras.sv | 42 ++++
 tb/tb_contador_palabras.sv | 132 +++++++++++++
 3 files changed

// File: rtl/contador_palabras_if.sv
// contador_palabras_if: pop/empty strobes, FSM status and probe-read port of the word counter
interface contador_palabras_if #(parameter int CNT_W = 5);
   logic             init;
   logic             idle;
   logic             pop_in0, pop_in1, pop_in2, pop_in3;
   logic             empty0, empty1, empty2, empty3;
   logic             req;
   logic [1:0]       idx;
   logic [CNT_W-1:0] contador;
   logic             valid;
   modport master (
      output init, idle, pop_in0, pop_in1, pop_in2, pop_in3,
             empty0, empty1, empty2, empty3, req, idx,
      input  contador, valid
   );
   modport slave (
      input  init, idle, pop_in0, pop_in1, pop_in2, pop_in3,
             empty0, empty1, empty2, empty3, req, idx,
      output contador, valid
   );
endinterface

// File: rtl/contador_palabras.sv
// contador_palabras: counts effective pops of four output FIFOs and serves probe reads while IDLE
module contador_palabras #(parameter int CNT_W = 5) (
   input logic               clk,
   input logic               reset,
   contador_palabras_if.slave bus
);
   typedef enum logic [1:0] {WAIT, PEND, RESP} state_t;
   state_t           state_q;
   logic [1:0]       idx_q;
   logic [CNT_W-1:0] contador_q;
   logic             valid_q;
   logic [CNT_W-1:0] cnt_q [4];
   logic [CNT_W-1:0] cnt_d [4];
   logic [3:0]       eff;
   logic             go;
   logic [1:0]       sel;
   always_comb begin
      eff = {bus.pop_in3 & ~bus.empty3, bus.pop_in2 & ~bus.empty2,
             bus.pop_in1 & ~bus.empty1, bus.pop_in0 & ~bus.empty0};
      for (int i = 0; i < 4; i++) cnt_d[i] = bus.init ? '0 : cnt_q[i] + CNT_W'(eff[i]);
      go  = (state_q == PEND) ? bus.idle : bus.req & bus.idle;
      sel = (state_q == PEND) ? idx_q : bus.idx;
   end
   always_ff @(posedge clk or negedge reset)
      if (!reset) for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
      else for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
   // The response samples cnt_q, i.e. the count before this edge's pop or clear.
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         state_q    <= WAIT;
         idx_q      <= '0;
         contador_q <= '0;
         valid_q    <= 1'b0;
      end else begin
         valid_q    <= go;
         contador_q <= go ? cnt_q[sel] : '0;
         state_q    <= go ? RESP : (state_q == PEND || bus.req) ? PEND : WAIT;
         if (state_q != PEND && bus.req) idx_q <= bus.idx;
      end
   assign bus.contador = contador_q;
   assign bus.valid    = valid_q;
endmodule

// File: tb/tb_contador_palabras.sv
// tb_contador_palabras: directed and random checks against a count-array reference model
module tb_contador_palabras;
   localparam int CNT_W = 5;
   localparam int M = 1 << CNT_W;
   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [3:0] pops = '0;
   logic [3:0] emps = '0;
   int         n_cmp = 0;
   int         n_err = 0;
   int         cnt [4] = '{0, 0, 0, 0};
   bit         m_pend = 0;
   int         m_pidx = 0;
   bit         m_valid = 0;
   int         m_cnt = 0;
   contador_palabras_if #(.CNT_W(CNT_W)) bus ();
   contador_palabras #(.CNT_W(CNT_W)) dut (.clk(clk), .reset(reset), .bus(bus));
   assign bus.pop_in0 = pops[0];
   assign bus.pop_in1 = pops[1];
   assign bus.pop_in2 = pops[2];
   assign bus.pop_in3 = pops[3];
   assign bus.empty0  = emps[0];
   assign bus.empty1  = emps[1];
   assign bus.empty2  = emps[2];
   assign bus.empty3  = emps[3];
   always #5 clk = ~clk;
   task automatic check(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, required %0d at %0t", nm, act, exp, $time);
      end
   endtask
   // Reference: pending flag plus plain modulo counts, outputs as seen after each edge.
   always @(posedge clk) if (reset) begin
      if (m_pend) begin
         m_valid = bus.idle;
         m_cnt   = bus.idle ? cnt[m_pidx] : 0;
         m_pend  = !bus.idle;
      end else if (bus.req && bus.idle) begin
         m_valid = 1; m_cnt = cnt[bus.idx];
      end else begin
         m_valid = 0; m_cnt = 0;
         if (bus.req) begin m_pend = 1; m_pidx = int'(bus.idx); end
      end
      for (int i = 0; i < 4; i++)
         cnt[i] = bus.init ? 0 : (pops[i] && !emps[i]) ? (cnt[i] + 1) % M : cnt[i];
   end
   always @(negedge reset) begin
      for (int i = 0; i < 4; i++) cnt[i] = 0;
      m_pend = 0; m_valid = 0; m_cnt = 0;
   end
   always @(negedge clk) begin
      check("model_valid", int'(bus.valid), int'(m_valid));
      check("model_contador", int'(bus.contador), m_cnt);
   end
   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask
   task automatic pop(input int f, input int n);
      for (int k = 0; k < n; k++) begin pops[f] = 1'b1; step(); end
      pops = '0;
   endtask
   task automatic rd(input int i, input int exp, input string nm);
      bus.req = 1'b1; bus.idx = 2'(i);
      step();
      bus.req = 1'b0;
      check({nm, "_valid"}, int'(bus.valid), 1);
      check(nm, int'(bus.contador), exp);
   endtask
   task automatic clear();
      bus.init = 1'b1; step(); bus.init = 1'b0;
   endtask
   initial begin
      bus.init = 1'b0; bus.idle = 1'b1; bus.req = 1'b0; bus.idx = '0;
      repeat (2) @(negedge clk);
      check("reset_valid", int'(bus.valid), 0);
      check("reset_contador", int'(bus.contador), 0);
      reset = 1'b1;
      step();
      pop(0, 3); pop(1, 1); pop(3, 5);
      rd(0, 3, "b2b_0"); rd(1, 1, "b2b_1"); rd(2, 0, "b2b_2"); rd(3, 5, "b2b_3");
      #2 reset = 1'b0;
      #1;
      check("async_rst_valid", int'(bus.valid), 0);
      check("async_rst_contador", int'(bus.contador), 0);
      @(negedge clk); @(negedge clk);
      reset = 1'b1;
      step();
      for (int k = 0; k < 6; k++) begin
         pops[2] = 1'b1; emps[2] = (k < 2); step();
      end
      pops = '0; emps = '0;
      rd(2, 4, "empty_gate");
      pop(1, 33);
      rd(1, 1, "wrap");
      clear();
      for (int k = 0; k < 7; k++) begin pops = 4'hF; step(); end
      pops = '0;
      for (int i = 0; i < 4; i++) rd(i, 7, "pre_init");
      bus.init = 1'b1; pops[0] = 1'b1; step(); bus.init = 1'b0; pops = '0;
      for (int i = 0; i < 4; i++) rd(i, 0, "post_init");
      pop(3, 4);
      bus.idle = 1'b0; bus.req = 1'b1; bus.idx = 2'd3; step();
      bus.idx = 2'd0; step();
      bus.req = 1'b0;
      for (int k = 0; k < 5; k++) begin step(); check("pend_quiet", int'(bus.valid), 0); end
      bus.idle = 1'b1; step();
      check("pend_valid", int'(bus.valid), 1);
      check("pend_contador", int'(bus.contador), 4);
      step();
      check("pend_single", int'(bus.valid), 0);
      clear();
      pop(2, 9);
      pops[2] = 1'b1; bus.req = 1'b1; bus.idx = 2'd2; step();
      pops = '0; bus.req = 1'b0;
      check("same_edge", int'(bus.contador), 9);
      rd(2, 10, "after_same_edge");
      for (int k = 0; k < 3000; k++) begin
         pops     = 4'($urandom);
         emps     = 4'($urandom) & 4'($urandom);
         bus.req  = 1'($urandom);
         bus.idx  = 2'($urandom);
         bus.idle = ($urandom_range(0, 3) != 0);
         bus.init = ($urandom_range(0, 63) == 0);
         step();
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
